// File: rtl/load_store_unit.sv
// load_store_unit: turns one load/store request at a time into word-aligned
// memory reads and writes. Sub-word stores are read-modify-write. Loads are
// extracted from the lane and sign/zero extended. Misaligned or illegal
// requests fault without touching memory.
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_address_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_fault_o,
    output logic [31:0] mem_read_address_o,
    input  logic [31:0] mem_read_data_i,
    output logic        mem_write_enable_o,
    output logic [31:0] mem_write_address_o,
    output logic [31:0] mem_write_data_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] READ_WAIT = 2'd1;
    localparam logic [1:0] WRITE     = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    localparam logic [2:0] CNT_INIT  = 3'(READ_LATENCY);

    // Returns 1 when the funct3/direction/alignment combination is illegal.
    function automatic logic is_fault(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] a);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = wr;
            3'b101:  bad = wr | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Picks the addressed byte/half out of the word and extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {lane, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b010:  r = word;
            3'b100:  r = {24'd0, s[7:0]};
            3'b101:  r = {16'd0, s[15:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Inserts the store byte/half into its lane, keeping the other lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] data;
        case (f3)
            3'b000:  mask = 32'h0000_00FF << {lane, 3'b000};
            3'b001:  mask = 32'h0000_FFFF << {lane, 3'b000};
            default: mask = 32'hFFFF_FFFF;
        endcase
        data = wdata << {lane, 3'b000};
        return (word & ~mask) | (data & mask);
    endfunction

    logic [1:0]  state_q,  state_d;
    logic        write_q,  write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q,   lane_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [2:0]  cnt_q,    cnt_d;
    logic [31:0] raddr_q,  raddr_d;
    logic [31:0] waddr_q,  waddr_d;
    logic [31:0] wword_q,  wword_d;
    logic        we_q,     we_d;
    logic        rvalid_q, rvalid_d;
    logic        rfault_q, rfault_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [31:0] aligned_s;

    assign aligned_s = {req_address_i[31:2], 2'b00};

    // Next-state and output computation for the request sequencer.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        wword_d  = wword_q;
        we_d     = 1'b0;
        rvalid_d = 1'b0;
        rfault_d = 1'b0;
        rdata_d  = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d  = req_write_i;
                    funct3_d = req_funct3_i;
                    lane_d   = req_address_i[1:0];
                    wdata_d  = req_wdata_i;
                    if (is_fault(req_write_i, req_funct3_i, req_address_i[1:0])) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rfault_d = 1'b1;
                    end else if (req_write_i && (req_funct3_i == 3'b010)) begin
                        // Full-word store needs no read.
                        state_d  = WRITE;
                        waddr_d  = aligned_s;
                        wword_d  = req_wdata_i;
                        we_d     = 1'b1;
                        rvalid_d = 1'b1;
                    end else begin
                        state_d  = READ_WAIT;
                        raddr_d  = aligned_s;
                        cnt_d    = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ_WAIT: begin
                if (cnt_q == 3'd1) begin
                    cnt_d    = 3'd0;
                    rvalid_d = 1'b1;
                    if (write_q) begin
                        state_d = WRITE;
                        waddr_d = raddr_q;
                        wword_d = store_merge(mem_read_data_i, wdata_q, funct3_q, lane_q);
                        we_d    = 1'b1;
                    end else begin
                        state_d = RESP;
                        rdata_d = load_extend(mem_read_data_i, funct3_q, lane_q);
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            lane_q   <= 2'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= 3'd0;
            raddr_q  <= 32'd0;
            waddr_q  <= 32'd0;
            wword_q  <= 32'd0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rfault_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            wword_q  <= wword_d;
            we_q     <= we_d;
            rvalid_q <= rvalid_d;
            rfault_q <= rfault_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ready_o         = (state_q == IDLE);
    assign resp_valid_o        = rvalid_q;
    assign resp_fault_o        = rfault_q;
    assign resp_rdata_o        = rdata_q;
    assign mem_read_address_o  = raddr_q;
    assign mem_write_enable_o  = we_q;
    assign mem_write_address_o = waddr_q;
    assign mem_write_data_o    = wword_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3), each with
// a memory model, a byte-level reference model and a queue-based scoreboard.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    bit done [2];

    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int          t0;
        int          lat;
        logic        fault;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L  = (g == 0) ? 1 : 3;
        localparam int PI = (L > 1) ? L - 2 : 0;

        logic        rst_n;
        logic        req_valid, req_ready, req_write;
        logic [2:0]  req_funct3;
        logic [31:0] req_address, req_wdata;
        logic        resp_valid, resp_fault;
        logic [31:0] resp_rdata;
        logic [31:0] mem_read_address, mem_read_data;
        logic        mem_write_enable;
        logic [31:0] mem_write_address, mem_write_data;

        logic [31:0] mem [0:63];
        logic [31:0] apipe [0:3];
        logic [31:0] rd_addr;
        logic [7:0]  rbytes [0:255];
        exp_t        sb_q [$];
        logic [31:0] last_raddr;
        bit          init_done = 1'b0;
        bit          ready_next;

        load_store_unit #(.READ_LATENCY(L)) dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .req_valid_i         (req_valid),
            .req_ready_o         (req_ready),
            .req_write_i         (req_write),
            .req_funct3_i        (req_funct3),
            .req_address_i       (req_address),
            .req_wdata_i         (req_wdata),
            .resp_valid_o        (resp_valid),
            .resp_rdata_o        (resp_rdata),
            .resp_fault_o        (resp_fault),
            .mem_read_address_o  (mem_read_address),
            .mem_read_data_i     (mem_read_data),
            .mem_write_enable_o  (mem_write_enable),
            .mem_write_address_o (mem_write_address),
            .mem_write_data_o    (mem_write_data)
        );

        // Memory read path delayed so data is valid L cycles after the address.
        always @(posedge clk) begin
            apipe[0] <= mem_read_address;
            for (int k = 1; k < 4; k++) apipe[k] <= apipe[k-1];
        end
        assign rd_addr       = (L == 1) ? mem_read_address : apipe[PI];
        assign mem_read_data = mem[rd_addr[7:2]];

        // Monitor: pops the scoreboard on every response and owns memory writes.
        initial begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            mem[4] = 32'h8765_43F1;
            mem[5] = 32'h1122_3344;
            ready_next = 1'b0;
            init_done  = 1'b1;
            forever begin
                exp_t e;
                @(negedge clk);
                if (ready_next) begin
                    chk($sformatf("L%0d ready_after_resp", L), {31'd0, req_ready}, 32'd1);
                    ready_next = 1'b0;
                end
                if (mem_write_enable)
                    chk($sformatf("L%0d write_needs_resp", L), {31'd0, resp_valid}, 32'd1);
                if (resp_valid) begin
                    ready_next = 1'b1;
                    if (sb_q.size() == 0) begin
                        chk($sformatf("L%0d unexpected_resp", L), 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("L%0d latency", L), 32'(edge_n - e.t0 + 1), 32'(e.lat));
                        chk($sformatf("L%0d fault", L), {31'd0, resp_fault}, {31'd0, e.fault});
                        chk($sformatf("L%0d rdata", L), resp_rdata, e.rdata);
                        chk($sformatf("L%0d write_enable", L), {31'd0, mem_write_enable}, {31'd0, e.we});
                        chk($sformatf("L%0d read_addr", L), mem_read_address, e.raddr);
                        if (e.we) begin
                            chk($sformatf("L%0d write_addr", L), mem_write_address, e.waddr);
                            chk($sformatf("L%0d write_data", L), mem_write_data, e.wdata);
                        end
                    end
                end
                if (mem_write_enable) mem[mem_write_address[7:2]] = mem_write_data;
            end
        end

        task automatic wait_ready();
            int n = 0;
            @(negedge clk);
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("L%0d ready_timeout", L), {31'd0, req_ready}, 32'd1);
        endtask

        task automatic check_reset_values();
            chk($sformatf("L%0d rst_ready", L), {31'd0, req_ready}, 32'd1);
            chk($sformatf("L%0d rst_resp_valid", L), {31'd0, resp_valid}, 32'd0);
            chk($sformatf("L%0d rst_fault", L), {31'd0, resp_fault}, 32'd0);
            chk($sformatf("L%0d rst_we", L), {31'd0, mem_write_enable}, 32'd0);
            chk($sformatf("L%0d rst_rdata", L), resp_rdata, 32'd0);
            chk($sformatf("L%0d rst_raddr", L), mem_read_address, 32'd0);
            chk($sformatf("L%0d rst_waddr", L), mem_write_address, 32'd0);
            chk($sformatf("L%0d rst_wdata", L), mem_write_data, 32'd0);
        endtask

        // Issues one request and pushes the reference model's expected response.
        task automatic issue(input bit w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
            exp_t        e;
            bit          legal;
            int          size;
            int          base;
            logic [31:0] v;
            wait_ready();
            req_write   = w;
            req_funct3  = f3;
            req_address = a;
            req_wdata   = wd;
            req_valid   = 1'b1;
            @(posedge clk);
            #1;
            e.t0        = edge_n;
            req_valid   = 1'b0;
            req_write   = 1'($urandom);
            req_funct3  = 3'($urandom);
            req_address = $urandom;
            req_wdata   = $urandom;

            legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
            size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            if (legal && (int'(a) % size) != 0) legal = 1'b0;
            base  = int'(a) & ~3;
            e.fault = !legal;
            e.rdata = 32'd0;
            e.we    = 1'b0;
            e.waddr = 32'd0;
            e.wdata = 32'd0;
            e.lat   = 1;
            if (legal && !w) begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v |= 32'(rbytes[int'(a) + i]) << (8 * i);
                if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8 * size)) - 32'd1);
                e.rdata    = v;
                e.lat      = L + 1;
                last_raddr = 32'(base);
            end else if (legal && w) begin
                for (int i = 0; i < size; i++) rbytes[int'(a) + i] = 8'(wd >> (8 * i));
                e.we    = 1'b1;
                e.waddr = 32'(base);
                e.wdata = {rbytes[base+3], rbytes[base+2], rbytes[base+1], rbytes[base]};
                if (size < 4) begin
                    e.lat      = L + 1;
                    last_raddr = 32'(base);
                end
            end
            e.raddr = last_raddr;
            sb_q.push_back(e);
        endtask

        // Reset during the read phase of a byte store, plus a request held in reset.
        task automatic reset_abort();
            wait_ready();
            req_write   = 1'b1;
            req_funct3  = 3'b000;
            req_address = 32'h20;
            req_wdata   = $urandom;
            req_valid   = 1'b1;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            rst_n     = 1'b0;
            last_raddr = 32'd0;
            #1;
            check_reset_values();
            @(negedge clk);
            req_write   = 1'b0;
            req_funct3  = 3'b010;
            req_address = 32'h10;
            req_valid   = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk($sformatf("L%0d ready_after_release", L), {31'd0, req_ready}, 32'd1);
        endtask

        // Driver: reset, directed plan, reset abort, random traffic, final image.
        initial begin
            int n;
            int bad;
            rst_n       = 1'b1;
            req_valid   = 1'b0;
            req_write   = 1'b0;
            req_funct3  = 3'd0;
            req_address = 32'd0;
            req_wdata   = 32'd0;
            last_raddr  = 32'd0;
            #1 rst_n = 1'b0;
            #2;
            check_reset_values();
            wait (init_done);
            for (int i = 0; i < 64; i++)
                for (int b = 0; b < 4; b++) rbytes[4*i+b] = 8'(mem[i] >> (8 * b));
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;

            issue(1'b0, 3'b000, 32'h10, 32'd0);
            issue(1'b0, 3'b100, 32'h10, 32'd0);
            issue(1'b0, 3'b000, 32'h11, 32'd0);
            issue(1'b0, 3'b001, 32'h12, 32'd0);
            issue(1'b0, 3'b101, 32'h12, 32'd0);
            issue(1'b0, 3'b010, 32'h10, 32'd0);
            issue(1'b1, 3'b001, 32'h16, 32'h0000_BEEF);
            issue(1'b1, 3'b000, 32'h13, 32'h1234_56AA);
            issue(1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF);
            issue(1'b0, 3'b010, 32'h12, 32'd0);
            issue(1'b1, 3'b001, 32'h01, 32'h0000_5555);
            issue(1'b0, 3'b011, 32'h10, 32'd0);
            reset_abort();
            issue(1'b0, 3'b010, 32'h10, 32'd0);
            repeat (150) issue(1'($urandom), 3'($urandom_range(0, 7)),
                               32'($urandom_range(0, 255)), $urandom);

            n = 0;
            while (sb_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("L%0d drain", L), 32'(sb_q.size()), 32'd0);
            bad = 0;
            for (int i = 0; i < 64; i++)
                if (mem[i] !== {rbytes[4*i+3], rbytes[4*i+2], rbytes[4*i+1], rbytes[4*i]})
                    bad++;
            chk($sformatf("L%0d mem_image", L), 32'(bad), 32'd0);
            done[g] = 1'b1;
        end
    end

    // Summary once both instances are finished.
    initial begin
        wait (done[0] && done[1]);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the controller and the memory module. It takes one load or store request at a time, with the RISC-V funct3 size/sign encoding, and turns it into word-aligned memory reads and writes. Sub-word stores are done as a read-modify-write. Loaded bytes and halfwords are extracted and sign- or zero-extended. Misaligned or illegal requests are reported as faults and never reach memory.

Parameters:
READ_LATENCY, 1, cycles from mem_read_address driven to mem_read_data valid; legal range 1-4.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted on req_valid && req_ready at a rising edge
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (size/sign)
req_address  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; 0 for stores and faults
resp_fault  out  1  qualifies resp_valid: misaligned or illegal funct3
mem_read_address  out  32  word-aligned byte address (req_address & ~3)
mem_read_data  in  32  memory read word
mem_write_enable  out  1  one-cycle write strobe
mem_write_address  out  32  word-aligned byte address
mem_write_data  out  32  full word to write

Behaviour:
- States: IDLE, READ_WAIT, WRITE, RESP.
- req_ready = (state == IDLE). Requests are ignored while rst_n is low.
- Reset values: state IDLE, so req_ready = 1. resp_valid, resp_fault and mem_write_enable = 0. resp_rdata, mem_read_address, mem_write_address and mem_write_data = 0. The latched request is cleared.
- Reset mid-operation aborts immediately: no write strobe is issued, no response is produced, and state returns to IDLE.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 faults.
- Alignment: halfword needs addr[0] = 0; word needs addr[1:0] = 0; otherwise fault.
- Memory is little-endian; byte lane = addr[1:0].
- Accept edge T0 latches the request and a lane offset, then branches:
  - Fault: go to RESP. At T0+1: resp_valid = 1, resp_fault = 1, resp_rdata = 0. No memory strobes.
  - Load or SB/SH: set mem_read_address; go to READ_WAIT with a down-counter of READ_LATENCY.
    - On the edge where the counter reaches 0, mem_read_data is captured.
    - Loads: extract and extend, go to RESP. resp_valid is high during cycle T0+READ_LATENCY+1.
    - SB/SH: merge the new byte/half into the captured word (other lanes preserved), go to WRITE.
  - SW: go to WRITE directly; mem_write_data = req_wdata.
- WRITE: mem_write_enable = 1 for exactly one cycle, with resp_valid = 1 and resp_rdata = 0 in the same cycle; then IDLE.
  - SW writes in cycle T0+1.
  - SB/SH write in cycle T0+READ_LATENCY+1, with exactly one read beforehand.
- RESP lasts one cycle; then IDLE.
- req_ready rises the cycle after resp_valid, so back-to-back throughput is one request per (latency+2) cycles.
- mem_read_address and mem_write_address hold their last values when unused.
- Request inputs are sampled only at accept; later changes are ignored.

Test Plan:
- Memory word 0x10 = 0x876543F1. LB 0x10 -> resp_rdata 0xFFFFFFF1; LBU 0x10 -> 0x000000F1; LB 0x11 -> 0x00000043. Each has resp_valid at T0+2 with READ_LATENCY = 1.
- Same word: LH 0x12 -> 0xFFFF8765; LHU 0x12 -> 0x00008765; LW 0x10 -> 0x876543F1.
- SB 0x13, wdata 0x123456AA -> one read of 0x10, then mem_write_enable at T0+2 with address 0x10, data 0xAA6543F1, resp_fault = 0.
- SW 0x14, wdata 0xDEADBEEF -> mem_write_enable at T0+1, address 0x14, data 0xDEADBEEF, no read. With READ_LATENCY = 3, SH 0x16 with wdata 0xBEEF over word 0x11223344 writes 0xBEEF3344 at T0+4.
- LW 0x12, SH 0x01, and funct3 011 load -> resp_valid = 1 and resp_fault = 1 at T0+1, resp_rdata = 0, no mem_write_enable.
- rst_n low during the READ_WAIT of an SB -> no mem_write_enable, no resp_valid, req_ready = 1 on release. The next LW then completes normally.
